ipa_ctx_sched: RTL and testbench

//  Context-load scheduler in front of the IPA context DMA. Arbitrates round-robin between NB_REQ

---
 rtl/ipa_ctx_sched.sv | 199 +++++++++++++++++++
 tb/tb_ipa_ctx_sched.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipa_ctx_sched.sv
// Context-load scheduler for the IPA context DMA: round-robin grant, one DMA fetch per job,
// then load/execution tracking with a per-phase watchdog and a done/error report to the owner.
module ipa_ctx_sched #(
    parameter int NB_REQ   = 4,
    parameter int ID_WIDTH = 5,
    parameter int TIMEOUT  = 1024
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [NB_REQ-1:0]          req_i,
    input  logic [NB_REQ*ID_WIDTH-1:0] id_i,
    output logic [NB_REQ-1:0]          gnt_o,
    output logic [NB_REQ-1:0]          done_o,
    output logic                       err_o,
    output logic [ID_WIDTH-1:0]        done_id_o,
    output logic                       dma_fetch_en_o,
    output logic [ID_WIDTH-1:0]        dma_cfg_id_o,
    input  logic                       dma_exec_en_i,
    input  logic                       exec_comp_i,
    output logic                       busy_o,
    output logic [$clog2(NB_REQ)-1:0]  owner_o
);

    localparam int              OW       = $clog2(NB_REQ);
    localparam bit              WD_ON    = (TIMEOUT > 0);
    localparam logic [15:0]     WD_LAST  = WD_ON ? 16'(TIMEOUT - 1) : 16'd0;
    localparam logic [OW:0]     NB_REQ_W = (OW + 1)'(NB_REQ);
    localparam logic [OW-1:0]   LAST_REQ = OW'(NB_REQ - 1);
    localparam logic [NB_REQ-1:0] ONE    = NB_REQ'(1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        LAUNCH,
        LOAD,
        EXEC,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [NB_REQ-1:0]          req_q;
    logic [NB_REQ*ID_WIDTH-1:0] id_q;
    logic [ID_WIDTH-1:0]        id_arr [NB_REQ];
    logic [OW-1:0]              owner_q, owner_d;
    logic [OW-1:0]              rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]        cfg_id_q, cfg_id_d;
    logic [15:0]                wd_cnt_q, wd_cnt_d;
    logic                       expired;

    logic [NB_REQ-1:0]          gnt_q, gnt_d;
    logic [NB_REQ-1:0]          done_q, done_d;
    logic                       err_q, err_d;
    logic [ID_WIDTH-1:0]        done_id_q, done_id_d;
    logic                       fetch_q, fetch_d;
    logic [ID_WIDTH-1:0]        dma_id_q, dma_id_d;
    logic                       busy_q, busy_d;

    for (genvar k = 0; k < NB_REQ; k++) begin : g_id
        assign id_arr[k] = id_q[k*ID_WIDTH +: ID_WIDTH];
    end

    // First requester at or above ptr, wrapping around.
    function automatic logic [OW-1:0] rr_pick(input logic [NB_REQ-1:0] req,
                                              input logic [OW-1:0]     ptr);
        logic [2*NB_REQ-1:0] rot;
        logic [OW:0]         off;
        logic [OW:0]         sum;
        logic                found;
        rot   = {req, req} >> ptr;
        off   = '0;
        found = 1'b0;
        for (int i = 0; i < NB_REQ; i++) begin
            if (!found && rot[0]) begin
                found = 1'b1;
                off   = (OW + 1)'(i);
            end
            rot = rot >> 1;
        end
        sum = {1'b0, ptr} + off;
        if (sum >= NB_REQ_W) sum = sum - NB_REQ_W;
        return sum[OW-1:0];
    endfunction

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cfg_id_d = cfg_id_q;
        wd_cnt_d = wd_cnt_q;
        expired  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_q) begin
                    owner_d  = rr_pick(req_q, rr_ptr_q);
                    cfg_id_d = id_arr[owner_d];
                    state_d  = GRANT;
                end
            end
            GRANT:  state_d = LAUNCH;
            LAUNCH: begin
                wd_cnt_d = '0;
                state_d  = LOAD;
            end
            LOAD: begin
                if (dma_exec_en_i) begin
                    wd_cnt_d = '0;
                    state_d  = exec_comp_i ? DONE : EXEC;
                end else if (WD_ON && wd_cnt_q == WD_LAST) begin
                    expired = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            EXEC: begin
                if (exec_comp_i) begin
                    state_d = DONE;
                end else if (WD_ON && wd_cnt_q == WD_LAST) begin
                    expired = 1'b1;
                    state_d = DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 16'd1;
                end
            end
            DONE: begin
                rr_ptr_d = (owner_q == LAST_REQ) ? '0 : owner_q + OW'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so each registered pulse lines up with its state.
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        done_id_d = '0;
        fetch_d   = 1'b0;
        dma_id_d  = '0;
        busy_d    = (state_d != IDLE);
        if (state_d == GRANT) gnt_d = ONE << owner_d;
        if (state_d == LAUNCH) begin
            fetch_d  = 1'b1;
            dma_id_d = cfg_id_d;
        end
        if (state_d == DONE) begin
            done_d    = ONE << owner_d;
            err_d     = expired;
            done_id_d = cfg_id_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the asynchronous reset clears
    // the request sampling stage too, so a job aborted by reset leaves nothing behind.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            id_q      <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cfg_id_q  <= '0;
            wd_cnt_q  <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            done_id_q <= '0;
            fetch_q   <= 1'b0;
            dma_id_q  <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_i;
            id_q      <= id_i;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            cfg_id_q  <= cfg_id_d;
            wd_cnt_q  <= wd_cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            done_id_q <= done_id_d;
            fetch_q   <= fetch_d;
            dma_id_q  <= dma_id_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt_o          = gnt_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign done_id_o      = done_id_q;
    assign dma_fetch_en_o = fetch_q;
    assign dma_cfg_id_o   = dma_id_q;
    assign busy_o         = busy_q;
    assign owner_o        = owner_q;

endmodule

// File: tb/tb_ipa_ctx_sched.sv
// Bench for ipa_ctx_sched: two instances (long and 16-cycle watchdog) share stimulus and are
// compared every cycle against a job-level reference model, plus hand-computed spot checks.
module tb_ipa_ctx_sched;

    localparam int N  = 4;
    localparam int IW = 5;

    typedef struct packed {
        logic [N-1:0]  gnt;
        logic [N-1:0]  done;
        logic          err;
        logic [IW-1:0] done_id;
        logic          fetch;
        logic [IW-1:0] cfg_id;
        logic          busy;
        logic [1:0]    owner;
    } outs_t;

    typedef struct {
        bit          active;
        bit          ending;
        bit          loaded;
        int          since_pick;
        int          wait_cnt;
        int          owner;
        int          ptr;
        logic [IW-1:0] id;
        logic [N-1:0]  seen_req;
        logic [IW-1:0] seen_id [N];
        outs_t       exp;
    } mdl_t;

    logic            Clk;
    logic            Reset;
    logic [N-1:0]    req;
    logic [N*IW-1:0] id_bus;
    logic            exen;
    logic            comp;

    logic [N-1:0]  gnt_a, done_a, gnt_b, done_b;
    logic          err_a, err_b, fetch_a, fetch_b, busy_a, busy_b;
    logic [IW-1:0] done_id_a, done_id_b, cfg_id_a, cfg_id_b;
    logic [1:0]    owner_a, owner_b;

    outs_t act [2];
    mdl_t  mdl [2];
    int    timeout_of [2] = '{1024, 16};

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    ipa_ctx_sched #(.NB_REQ(N), .ID_WIDTH(IW), .TIMEOUT(1024)) u_dut_a (
        .Clk(Clk), .Reset(Reset), .req_i(req), .id_i(id_bus),
        .gnt_o(gnt_a), .done_o(done_a), .err_o(err_a), .done_id_o(done_id_a),
        .dma_fetch_en_o(fetch_a), .dma_cfg_id_o(cfg_id_a),
        .dma_exec_en_i(exen), .exec_comp_i(comp), .busy_o(busy_a), .owner_o(owner_a)
    );

    ipa_ctx_sched #(.NB_REQ(N), .ID_WIDTH(IW), .TIMEOUT(16)) u_dut_b (
        .Clk(Clk), .Reset(Reset), .req_i(req), .id_i(id_bus),
        .gnt_o(gnt_b), .done_o(done_b), .err_o(err_b), .done_id_o(done_id_b),
        .dma_fetch_en_o(fetch_b), .dma_cfg_id_o(cfg_id_b),
        .dma_exec_en_i(exen), .exec_comp_i(comp), .busy_o(busy_b), .owner_o(owner_b)
    );

    assign act[0] = {gnt_a, done_a, err_a, done_id_a, fetch_a, cfg_id_a, busy_a, owner_a};
    assign act[1] = {gnt_b, done_b, err_b, done_id_b, fetch_b, cfg_id_b, busy_b, owner_b};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Ids only matter while their valid strobe is high.
    function automatic outs_t visible(input outs_t o);
        outs_t v;
        v = o;
        if (o.done == '0) v.done_id = '0;
        if (!o.fetch) v.cfg_id = '0;
        return v;
    endfunction

    task automatic model_reset(input int i);
        mdl_t m;
        m.active = 0; m.ending = 0; m.loaded = 0;
        m.since_pick = 0; m.wait_cnt = 0; m.owner = 0; m.ptr = 0;
        m.id = '0; m.seen_req = '0; m.exp = '0;
        for (int k = 0; k < N; k++) m.seen_id[k] = '0;
        mdl[i] = m;
    endtask

    // One clock edge of the job-level model; inputs are those present before the edge.
    task automatic model_step(input int i);
        mdl_t m;
        bit   finish, fail;
        m = mdl[i];
        finish = 0;
        fail   = 0;
        m.exp.gnt = '0; m.exp.done = '0; m.exp.err = 0;
        m.exp.done_id = '0; m.exp.fetch = 0; m.exp.cfg_id = '0;
        if (m.ending) begin
            m.active = 0;
            m.ending = 0;
        end else if (!m.active) begin
            if (m.seen_req != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    int c;
                    c = (m.ptr + k) % N;
                    if (m.seen_req[c]) m.owner = c;
                end
                m.id = m.seen_id[m.owner];
                m.active = 1;
                m.since_pick = 1;
                m.exp.gnt = N'(1 << m.owner);
            end
        end else begin
            m.since_pick++;
            if (m.since_pick == 2) begin
                m.exp.fetch  = 1;
                m.exp.cfg_id = m.id;
            end else if (m.since_pick == 3) begin
                m.loaded = 0;
                m.wait_cnt = 0;
            end else if (!m.loaded && exen) begin
                if (comp) finish = 1;
                else begin
                    m.loaded = 1;
                    m.wait_cnt = 0;
                end
            end else if (m.loaded && comp) begin
                finish = 1;
            end else if (timeout_of[i] > 0 && m.wait_cnt == timeout_of[i] - 1) begin
                finish = 1;
                fail = 1;
            end else begin
                m.wait_cnt++;
            end
            if (finish) begin
                m.exp.done    = N'(1 << m.owner);
                m.exp.err     = fail;
                m.exp.done_id = m.id;
                m.ending      = 1;
                m.ptr         = (m.owner + 1) % N;
            end
        end
        m.seen_req = req;
        for (int k = 0; k < N; k++) m.seen_id[k] = id_bus[k*IW +: IW];
        m.exp.busy  = m.active;
        m.exp.owner = 2'(m.owner);
        mdl[i] = m;
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++)
            check($sformatf("cycle%0d_dut_%s", cyc, (i == 0) ? "a" : "b"),
                  64'(visible(act[i])), 64'(mdl[i].exp));
    endtask

    // Advance one cycle: model at the edge, compare on the falling edge, requesters drop on grant.
    task automatic tick();
        @(posedge Clk);
        for (int i = 0; i < 2; i++) begin
            if (!Reset) model_reset(i);
            else model_step(i);
        end
        @(negedge Clk);
        cyc++;
        compare_all();
        req = req & ~(mdl[0].exp.gnt | mdl[1].exp.gnt);
    endtask

    task automatic async_reset();
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) model_reset(i);
        compare_all();
        req = '0; exen = 0; comp = 0;
        tick();
        tick();
        Reset = 1'b1;
    endtask

    task automatic raise(input int k, input logic [IW-1:0] id);
        req[k] = 1'b1;
        id_bus[k*IW +: IW] = id;
    endtask

    task automatic wait_fetch(input int which, output int f);
        int budget;
        budget = 0;
        while (!((which == 0) ? fetch_a : fetch_b) && budget < 50) begin
            tick();
            budget++;
        end
        check("wait_fetch", (which == 0) ? fetch_a : fetch_b, 1'b1);
        f = cyc;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((busy_a || busy_b) && budget < 2000) begin
            tick();
            budget++;
        end
        check("wait_idle", {busy_a, busy_b}, 2'b00);
    endtask

    function automatic int owner_of(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int k = 0; k < N; k++) if (g[k]) r = k;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t0, f, n;
        int exp_order [6] = '{0, 1, 2, 3, 1, 3};

        Reset = 1'b0; req = '0; id_bus = '0; exen = 0; comp = 0;
        for (int i = 0; i < 2; i++) model_reset(i);
        tick();
        tick();
        check("reset_outputs_a", 64'(act[0]), 64'd0);
        check("reset_outputs_b", 64'(act[1]), 64'd0);
        Reset = 1'b1;
        tick();

        // Single job on the long-watchdog instance.
        raise(2, 5'd9);
        t0 = cyc;
        tick();
        tick();
        check("t1_gnt", gnt_a, 4'b0100);
        tick();
        check("t1_fetch", {fetch_a, cfg_id_a}, {1'b1, 5'd9});
        while (cyc < t0 + 20) tick();
        exen = 1; tick(); exen = 0;
        while (cyc < t0 + 40) tick();
        comp = 1; tick(); comp = 0;
        check("t1_done", {done_a, done_id_a, err_a}, {4'b0100, 5'd9, 1'b0});
        wait_idle();

        // Fairness with both pulses held high, so every job also takes the coincident-pulse path.
        async_reset();
        for (int k = 0; k < N; k++) raise(k, 5'(10 + k));
        exen = 1; comp = 1;
        n = 0;
        for (int b = 0; b < 200 && n < 6; b++) begin
            tick();
            if (gnt_a != '0) begin
                check($sformatf("t2_order%0d", n), owner_of(gnt_a), exp_order[n]);
                n++;
                if (n == 4) begin
                    raise(1, 5'd21);
                    raise(3, 5'd23);
                end
            end
        end
        check("t2_grants_seen", n, 6);
        wait_idle();
        exen = 0; comp = 0;
        tick();

        // Watchdog on the 16-cycle instance: no load-done pulse ever arrives.
        raise(0, 5'd3);
        wait_fetch(1, f);
        while (cyc < f + 17) tick();
        check("t3_wd_done_err", {done_b, err_b, done_id_b}, {4'b0001, 1'b1, 5'd3});
        tick();
        check("t3_wd_idle", busy_b, 1'b0);
        exen = 1; tick(); exen = 0;
        comp = 1; tick(); comp = 0;
        wait_idle();

        // Coincident pulses in the first load cycle skip the execution phase.
        raise(1, 5'd17);
        wait_fetch(0, f);
        tick();
        exen = 1; comp = 1; tick(); exen = 0; comp = 0;
        check("t4_done_next", {done_a, err_a, done_id_a}, {4'b0010, 1'b0, 5'd17});
        tick();
        check("t4_idle_after", busy_a, 1'b0);

        // Stray completion in idle, then reset in the middle of execution.
        comp = 1; tick(); comp = 0;
        check("t5_stray", {busy_a, done_a, err_a, gnt_a}, 10'd0);
        raise(3, 5'd30);
        wait_fetch(0, f);
        tick();
        exen = 1; tick(); exen = 0;
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check("t5_rst_a", 64'(act[0]), 64'd0);
        check("t5_rst_b", 64'(act[1]), 64'd0);
        Reset = 1'b1;
        @(negedge Clk);
        async_reset();
        raise(2, 5'd7);
        t0 = cyc;
        tick();
        tick();
        check("t5_regrant", {gnt_a, owner_a}, {4'b0100, 2'd2});
        wait_fetch(0, f);
        tick();
        exen = 1; comp = 1; tick(); exen = 0; comp = 0;
        wait_idle();

        // Randomised traffic with occasional resets.
        for (int r = 0; r < 3000; r++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(7) == 0) raise(k, 5'($urandom));
                else if (req[k] && $urandom_range(31) == 0) req[k] = 1'b0;
            end
            exen = ($urandom_range(5) == 0);
            comp = ($urandom_range(5) == 0);
            if ($urandom_range(599) == 0) async_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
